// File: rtl/div_pkg.sv
// Shared types and helpers for the signed multi-cycle divider (div_sequencer).
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_CORR = 3'd3,
    ST_SIGN = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division step on the packed {acc, quotient} register.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] aq_i,
  input  logic [WIDTH-1:0] mp_i,
  output logic [2*WIDTH:0] aq_o
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   acc;

  // The accumulator sign is unchanged by the shift because |acc| < Mp <= 2^(WIDTH-1).
  always_comb begin
    shifted = {aq_i[2*WIDTH-1:0], 1'b0};
    if (!aq_i[2*WIDTH]) begin
      acc = shifted[2*WIDTH:WIDTH] - {1'b0, mp_i};
    end else begin
      acc = shifted[2*WIDTH:WIDTH] + {1'b0, mp_i};
    end
    aq_o = {acc, shifted[WIDTH-1:1], ~acc[WIDTH]};
  end

endmodule

// File: rtl/div_sequencer.sv
// Signed WIDTH/WIDTH non-restoring divider, one quotient bit per clock, C = {rem, quot}.
// Optional build macro DIV_ZERO_TRAP_EN adds the div_zero output and a short B==0 path.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic               div_zero
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH:0]   aq_q, aq_d;
  logic [WIDTH-1:0]   mp_q, mp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] c_q, c_d;
`ifdef DIV_ZERO_TRAP_EN
  logic               dz_q, dz_d;
`endif

  logic [2*WIDTH:0]   aq_step;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   quot_s, rem_s;
  logic               sign_a, sign_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .aq_i (aq_q),
    .mp_i (mp_q),
    .aq_o (aq_step)
  );

  // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1).
  assign sign_a = a_q[WIDTH-1];
  assign sign_b = b_q[WIDTH-1];
  assign abs_a  = sign_a ? -a_q : a_q;
  assign abs_b  = sign_b ? -b_q : b_q;
  assign quot_s = (sign_a ^ sign_b) ? -aq_q[WIDTH-1:0] : aq_q[WIDTH-1:0];
  assign rem_s  = sign_a ? -aq_q[2*WIDTH-1:WIDTH] : aq_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    aq_d    = aq_q;
    mp_d    = mp_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
`ifdef DIV_ZERO_TRAP_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        aq_d  = {{(WIDTH+1){1'b0}}, abs_a};
        mp_d  = abs_b;
        cnt_d = '0;
`ifdef DIV_ZERO_TRAP_EN
        if (b_q == '0) begin
          c_d     = {a_q, {WIDTH{1'b1}}};
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ITER;
        end
`else
        state_d = ST_ITER;
`endif
      end
      ST_ITER: begin
        aq_d  = aq_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_CORR;
        end
      end
      ST_CORR: begin
        if (aq_q[2*WIDTH]) begin
          aq_d[2*WIDTH:WIDTH] = aq_q[2*WIDTH:WIDTH] + {1'b0, mp_q};
        end
        state_d = ST_SIGN;
      end
      ST_SIGN: begin
        // Truncating division: remainder follows the dividend's sign.
        c_d     = {rem_s, quot_s};
        state_d = ST_DONE;
      end
      ST_DONE: begin
`ifdef DIV_ZERO_TRAP_EN
        dz_d    = 1'b0;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      aq_q    <= '0;
      mp_q    <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
`ifdef DIV_ZERO_TRAP_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aq_q    <= aq_d;
      mp_q    <= mp_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
`ifdef DIV_ZERO_TRAP_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy = (state_q == ST_PREP) || (state_q == ST_ITER) ||
                (state_q == ST_CORR) || (state_q == ST_SIGN);
  assign done = (state_q == ST_DONE);
  assign C    = c_q;
`ifdef DIV_ZERO_TRAP_EN
  assign div_zero = dz_q;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random operands
// compared against plain signed arithmetic.
module tb_div_sequencer;

  localparam int W = 32;

  logic           clock = 1'b0;
  logic           clear;
  logic           start;
  logic [W-1:0]   A, B;
  logic           busy, done;
  logic [2*W-1:0] C;
`ifdef DIV_ZERO_TRAP_EN
  logic           div_zero;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  div_sequencer #(.WIDTH(W)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .C        (C)
`ifdef DIV_ZERO_TRAP_EN
    ,
    .div_zero (div_zero)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating signed division; B==0 follows the documented fallback.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
`ifdef DIV_ZERO_TRAP_EN
      return {a, 32'hFFFF_FFFF};
`else
      return {a, (sa < 0) ? 32'd1 : 32'hFFFF_FFFF};
`endif
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_latency(input logic [31:0] b);
`ifdef DIV_ZERO_TRAP_EN
    if (b == 32'd0) return 1;
`endif
    return W + 3;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int k;
    int nbusy;
    bit got;
    logic [63:0] exp;
    exp = ref_div(a, b);
    @(negedge clock);
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    k = 0;
    nbusy = 0;
    got = 1'b0;
    while (k < 100) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nbusy++;
      k++;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(k), 64'(ref_latency(b)));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(ref_latency(b)));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_C"}, C, exp);
`ifdef DIV_ZERO_TRAP_EN
    check({tag, "_div_zero"}, 64'(div_zero), 64'(b == 32'd0));
`endif
    @(negedge clock);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_C_held"}, C, exp);
    $display("op %s: A=%h B=%h C=%h latency=%0d", tag, a, b, C, k);
  endtask

  localparam int ND = 12;
  logic [31:0] da [ND] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000,
                           32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000,
                           32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'h1234_5678};
  logic [31:0] db [ND] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                           32'hFFFF_FFF9, 32'd0, 32'd0, 32'd1,
                           32'h8000_0000, 32'h8000_0000, 32'd5, 32'd1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a1, b1, a2, b2, ra, rb;
    int ndone;
    int k;

    // Reset state
    clear = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_C", C, 64'd0);
`ifdef DIV_ZERO_TRAP_EN
    check("reset_div_zero", 64'(div_zero), 64'd0);
`endif
    @(negedge clock);
    clear = 1'b0;

    // Fixed expectations for the headline example
    check("ref_100_7", ref_div(32'd100, 32'd7), {32'd2, 32'd14});

    for (int i = 0; i < ND; i++) begin
      run_op($sformatf("dir%0d", i), da[i], db[i]);
    end

    // start held high with A/B churning: one result per accepted start
    a1 = 32'hFFFF_FC18;
    b1 = 32'd33;
    a2 = 32'd123457;
    b2 = 32'hFFFF_FFF3;
    @(negedge clock);
    start = 1'b1;
    A = a1;
    B = b1;
    @(posedge clock);
    ndone = 0;
    k = 0;
    while (k < 150) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("held_first_C", C, ref_div(a1, b1));
          A = a2;
          B = b2;
        end else begin
          check("held_second_C", C, ref_div(a2, b2));
          break;
        end
      end else if (ndone == 0) begin
        A = $urandom;
        B = $urandom;
      end else if (busy) begin
        start = 1'b0;
      end
      k++;
    end
    start = 1'b0;
    check("held_done_count", 64'(ndone), 64'd2);
    $display("op held: first A=%h B=%h second A=%h B=%h dones=%0d", a1, b1, a2, b2, ndone);

    // Asynchronous clear in the middle of an operation
    @(negedge clock);
    start = 1'b1;
    A = 32'd1000;
    B = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (19) @(negedge clock);
    #1;
    clear = 1'b1;
    #1;
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_done", 64'(done), 64'd0);
    check("clear_C", C, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("clear_no_done", 64'(ndone), 64'd0);
    $display("op clear: aborted mid-operation, dones afterwards=%0d", ndone);
    run_op("after_clear", 32'd1000, 32'd3);

    // Random operands
    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if ($urandom_range(0, 4) == 0) ra = 32'($urandom_range(0, 50));
      run_op($sformatf("rnd%0d", i), ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
